// File: rtl/sd_dac_ctrl.sv
// Sample-stream front end for the sigma_delta modulator, with a pop-free ramp on enable/disable.
// Optional build macro SD_DAC_CTRL_DITHER_EN adds 1-LSB LFSR dither on played samples.

// Small synchronous FIFO with count-based full/empty and a synchronous flush.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: none internally; the caller gates push on count < depth and pop on count != 0.
module sd_dac_fifo #(
  parameter int W  = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!n_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only words below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
endmodule

// Ramps dac_in 0->midscale, then plays one FIFO sample per DIV cycles, then ramps back to 0.
// Latency: a sample is loaded on the edge after the tick cycle; first tick is DIV cycles into PLAY.
// Backpressure: s_ready is low outside RAMP_UP/PLAY and while the FIFO holds 2**FIFO_AW samples.
module sd_dac_ctrl #(
  parameter int N       = 16,
  parameter int FIFO_AW = 2,
  parameter int DIV     = 64,
  parameter int STEP    = 16
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         enable,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  output logic [N-1:0] dac_in,
  output logic         underrun,
  output logic         active
);
  localparam int            DEPTH  = 1 << FIFO_AW;
  localparam int            CW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [N-1:0]  MID    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  STEP_N = N'(STEP);
  localparam logic [CW-1:0] TICK_AT = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    PLAY,
    SETTLE,
    RAMP_DOWN
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   dac_nxt;
  logic [CW-1:0]  tick_cnt;
  logic           tick;
  logic           tick_empty;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_flush;
  logic [N-1:0]   fifo_dat;
  logic [FIFO_AW:0] fifo_cnt;
  logic           fifo_empty;

  logic [N:0]     up_sum;
  logic [N-1:0]   ramp_up_val;
  logic [N-1:0]   ramp_dn_val;
  logic [N-1:0]   settle_val;
  logic [N-1:0]   conv_word;
  logic [N-1:0]   pop_word;

  sd_dac_fifo #(
    .W  (N),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .n_reset  (n_reset),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_dat (s_data),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .count    (fifo_cnt)
  );

  assign fifo_empty = (fifo_cnt == '0);
  // Ready depends only on registered state and count, so a full FIFO never
  // accepts a word even on a cycle where it is also being popped.
  assign s_ready    = ((state == RAMP_UP) || (state == PLAY)) &&
                      (fifo_cnt < (FIFO_AW+1)'(DEPTH));
  assign fifo_push  = s_valid && s_ready;
  assign active     = (state != IDLE);
  assign tick       = (tick_cnt == TICK_AT);

  // Saturating ramp arithmetic; the up-ramp sum is carried at N+1 bits.
  assign up_sum      = {1'b0, dac_in} + {1'b0, STEP_N};
  assign ramp_up_val = (up_sum >= {1'b0, MID}) ? MID : up_sum[N-1:0];
  assign ramp_dn_val = (dac_in >= STEP_N) ? (dac_in - STEP_N) : '0;

  always_comb begin
    settle_val = MID;
    if (dac_in > MID) begin
      if ((dac_in - MID) > STEP_N) settle_val = dac_in - STEP_N;
    end else if (dac_in < MID) begin
      if ((MID - dac_in) > STEP_N) settle_val = dac_in + STEP_N;
    end
  end

  assign conv_word = {~fifo_dat[N-1], fifo_dat[N-2:0]};

`ifdef SD_DAC_CTRL_DITHER_EN
  logic [15:0] lfsr;
  logic [N:0]  dith_sum;

  // Right-shifting Fibonacci form of the 16,14,13,11 polynomial.
  always_ff @(posedge clk) begin
    if (!n_reset) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign dith_sum = {1'b0, conv_word} + {{N{1'b0}}, lfsr[0]};
  assign pop_word = dith_sum[N] ? {N{1'b1}} : dith_sum[N-1:0];
`else
  assign pop_word = conv_word;
`endif

  always_comb begin
    state_nxt  = state;
    dac_nxt    = dac_in;
    fifo_pop   = 1'b0;
    tick_empty = 1'b0;
    case (state)
      IDLE: begin
        dac_nxt = '0;
        if (enable) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable)             state_nxt = RAMP_DOWN;
        else if (dac_in == MID)  state_nxt = PLAY;
        else                     dac_nxt   = ramp_up_val;
      end
      PLAY: begin
        if (!enable) begin
          state_nxt = SETTLE;
        end else if (tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            dac_nxt  = pop_word;
          end else begin
            tick_empty = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (dac_in == MID) state_nxt = RAMP_DOWN;
        else               dac_nxt   = settle_val;
      end
      RAMP_DOWN: begin
        if (dac_in == '0) state_nxt = IDLE;
        else              dac_nxt   = ramp_dn_val;
      end
      default: begin
        state_nxt = IDLE;
        dac_nxt   = '0;
      end
    endcase
  end

  // Anything queued is dropped as soon as shutdown begins.
  assign fifo_flush = ((state_nxt == SETTLE)    && (state != SETTLE)) ||
                      ((state_nxt == RAMP_DOWN) && (state != RAMP_DOWN));

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= IDLE;
      dac_in   <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      dac_in   <= dac_nxt;
      underrun <= tick_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset)            tick_cnt <= '0;
    else if (state != PLAY)  tick_cnt <= '0;
    else if (tick)           tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + 1'b1;
  end
endmodule
